// File: rtl/imhotep_pkg.sv
// Shared types and constants for the imhotep core front end.
// Fetch entries pair each returned instruction word with the PC it was fetched from.
package imhotep_pkg;

  // addi x0, x0, 0: presented to the decoder whenever no real instruction is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush.
// The caller guarantees no push into a full FIFO and no pop from an empty one.
module fetch_fifo
  import imhotep_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order word fetches over req/gnt/rvalid and
// buffers {pc, instr} pairs for the decoder, flushing on control-flow redirects.
module fetch_stage
  import imhotep_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW1-1:0] DEPTH_W = CW1'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW1-1:0] credit;
  logic          fifo_empty;
  logic          fifo_full;
  logic          grant;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign target  = word_align(redirect_pc_i);
  assign valid_o = ~fifo_empty;
  assign pop     = valid_o & ~stall_i & ~redirect_i;

  // Stale in-flight responses still hold credit, so total memory traffic never exceeds the depth.
  assign credit     = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req_o = (credit < DEPTH_W) & ~redirect_i & ~rst_i;
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o & imem_gnt_i;

  assign push      = imem_rvalid_i & (discard == '0) & ~redirect_i;
  assign push_data = '{pc: resp_pc, instr: imem_rdata_i};

  assign instr_o = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_o    = fifo_empty ? 32'h0     : head.pc;

  // outstanding counts every granted request; discard is the subset of those whose
  // responses belong to a superseded path, so a redirect marks all of them stale.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      fetch_pc    <= target;
      resp_pc     <= target;
      outstanding <= outstanding - CW'(imem_rvalid_i);
      discard     <= outstanding - CW'(imem_rvalid_i);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push)  resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
      if (imem_rvalid_i && discard != '0) discard <= discard - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // The credit check makes a push into a full, non-draining FIFO unreachable.
  no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop));

endmodule
